pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core. Generates stall/flush controls for the PC, if_id and id_exe registers, plus an exe_mem bubble.
- Handles three events:
  - load-use hazards detected in ID;
  - multi-cycle EXE operations (divider, CSR waits);
  - taken branch/jump redirects resolved in EXE.
- Synchronous instruction ROM means a redirect costs two flushed fetch slots.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl_hazard_det.sv | 25 ++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// State encodings, stall/flush polarities and the zero-register index
// live here so the controller and the hazard comparator agree on them.
package pipe_ctrl_pkg;

    // Controller states (2-bit encoding).
    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_MC_WAIT = 2'd1,
        PC_FLUSH   = 2'd2
    } pc_state_e;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;
    localparam logic FLUSH_ENABLE  = 1'b1;
    localparam logic FLUSH_DISABLE = 1'b0;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs and stall/flush outputs between the pipeline
// datapath (master) and the sequencing controller (slave).
interface pipe_ctrl_if #(
    parameter int RADDR_WIDTH = 5
);
    logic [RADDR_WIDTH-1:0] id_rs1_raddr_i;
    logic                   id_rs1_re_i;
    logic [RADDR_WIDTH-1:0] id_rs2_raddr_i;
    logic                   id_rs2_re_i;
    logic                   exe_mem_read_i;
    logic [RADDR_WIDTH-1:0] exe_reg_waddr_i;
    logic                   exe_mc_start_i;
    logic                   exe_mc_done_i;
    logic                   exe_branch_taken_i;

    logic                   pc_stall_o;
    logic                   if_id_stall_o;
    logic                   if_id_flush_o;
    logic                   id_exe_stall_o;
    logic                   id_exe_flush_o;
    logic                   exe_mem_flush_o;
    logic                   mc_timeout_o;
    logic [31:0]            stall_cycles_o;
    logic [31:0]            flush_cycles_o;

    modport master (
        output id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
               exe_mem_read_i, exe_reg_waddr_i, exe_mc_start_i,
               exe_mc_done_i, exe_branch_taken_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o,
               id_exe_flush_o, exe_mem_flush_o, mc_timeout_o,
               stall_cycles_o, flush_cycles_o
    );

    modport slave (
        input  id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
               exe_mem_read_i, exe_reg_waddr_i, exe_mc_start_i,
               exe_mc_done_i, exe_branch_taken_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o,
               id_exe_flush_o, exe_mem_flush_o, mc_timeout_o,
               stall_cycles_o, flush_cycles_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use comparator: flags when the load in EXE writes a register that
// the instruction in ID actually reads. Purely combinational.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
#(
    parameter int RADDR_WIDTH = 5
) (
    input  logic [RADDR_WIDTH-1:0] rs1_raddr_i,
    input  logic                   rs1_re_i,
    input  logic [RADDR_WIDTH-1:0] rs2_raddr_i,
    input  logic                   rs2_re_i,
    input  logic                   exe_mem_read_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    output logic                   hazard_o
);

    // Match either read port against the load destination, excluding x0.
    always_comb begin
        hazard_o = exe_mem_read_i
                && (exe_reg_waddr_i != RADDR_WIDTH'(ZERO_REG))
                && ((rs1_re_i && (rs1_raddr_i == exe_reg_waddr_i))
                 || (rs2_re_i && (rs2_raddr_i == exe_reg_waddr_i)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Produces PC / if_id / id_exe stall and flush controls plus an exe_mem
// bubble for load-use hazards, multi-cycle EXE ops and taken redirects.
// A redirect flushes two fetch slots because the instruction ROM is
// synchronous. Controls are combinational and take effect at the next edge.
// Optional build macro PIPE_CTRL_PERF_EN enables the stall/flush cycle
// counters; without it both counter outputs are constant zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RADDR_WIDTH = 5,
    parameter int MC_TIMEOUT  = 64,
    parameter int CNT_WIDTH   = 7   // 2**CNT_WIDTH must exceed MC_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,             // asynchronous, active-low
    pipe_ctrl_if.slave bus
);

    pc_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   hazard;

    logic pc_stall, if_id_stall, if_id_flush;
    logic id_exe_stall, id_exe_flush, exe_mem_flush, mc_timeout;

    pipe_hazard_det #(
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_hazard_det (
        .rs1_raddr_i     (bus.id_rs1_raddr_i),
        .rs1_re_i        (bus.id_rs1_re_i),
        .rs2_raddr_i     (bus.id_rs2_raddr_i),
        .rs2_re_i        (bus.id_rs2_re_i),
        .exe_mem_read_i  (bus.exe_mem_read_i),
        .exe_reg_waddr_i (bus.exe_reg_waddr_i),
        .hazard_o        (hazard)
    );

    // State and multi-cycle wait counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= PC_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control decode; each state lists its responses by priority.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_stall      = STALL_DISABLE;
        if_id_stall   = STALL_DISABLE;
        id_exe_stall  = STALL_DISABLE;
        if_id_flush   = FLUSH_DISABLE;
        id_exe_flush  = FLUSH_DISABLE;
        exe_mem_flush = FLUSH_DISABLE;
        mc_timeout    = 1'b0;

        case (state_q)
            PC_RUN: begin
                if (bus.exe_branch_taken_i) begin
                    // Kill the instructions in IF and ID; the next ROM word
                    // is also wrong-path and is killed from FLUSH.
                    if_id_flush  = FLUSH_ENABLE;
                    id_exe_flush = FLUSH_ENABLE;
                    state_d      = PC_FLUSH;
                end else if (bus.exe_mc_start_i && !bus.exe_mc_done_i) begin
                    pc_stall      = STALL_ENABLE;
                    if_id_stall   = STALL_ENABLE;
                    id_exe_stall  = STALL_ENABLE;
                    exe_mem_flush = FLUSH_ENABLE;
                    cnt_d         = CNT_WIDTH'(1);
                    state_d       = PC_MC_WAIT;
                end else if (bus.exe_mc_start_i) begin
                    // Finished in its first cycle: behaves like a plain op.
                    state_d = PC_RUN;
                end else if (hazard) begin
                    // Hold IF/ID one cycle and insert a bubble behind the load.
                    pc_stall     = STALL_ENABLE;
                    if_id_stall  = STALL_ENABLE;
                    id_exe_flush = FLUSH_ENABLE;
                end
            end

            PC_MC_WAIT: begin
                if (bus.exe_mc_done_i) begin
                    state_d = PC_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_WIDTH'(MC_TIMEOUT)) begin
                    // Give up on a unit that never answers; let the pipe move.
                    mc_timeout = 1'b1;
                    state_d    = PC_RUN;
                    cnt_d      = '0;
                end else begin
                    pc_stall      = STALL_ENABLE;
                    if_id_stall   = STALL_ENABLE;
                    id_exe_stall  = STALL_ENABLE;
                    exe_mem_flush = FLUSH_ENABLE;
                    cnt_d         = cnt_q + CNT_WIDTH'(1);
                end
            end

            PC_FLUSH: begin
                // EXE holds a bubble here, so redirects and hazards are moot.
                if_id_flush = FLUSH_ENABLE;
                state_d     = PC_RUN;
            end

            default: begin
                state_d = PC_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces every control low, even with live hazard inputs.
    assign bus.pc_stall_o      = rst_i & pc_stall;
    assign bus.if_id_stall_o   = rst_i & if_id_stall;
    assign bus.if_id_flush_o   = rst_i & if_id_flush;
    assign bus.id_exe_stall_o  = rst_i & id_exe_stall;
    assign bus.id_exe_flush_o  = rst_i & id_exe_flush;
    assign bus.exe_mem_flush_o = rst_i & exe_mem_flush;
    assign bus.mc_timeout_o    = rst_i & mc_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running stall/flush cycle counters; wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles_o = stall_cnt_q;
    assign bus.flush_cycles_o = flush_cnt_q;
`else
    assign bus.stall_cycles_o = 32'd0;
    assign bus.flush_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table plus hand-written
// multi-cycle sequences (long MC op, timeout, asynchronous reset).
// Output vector bit order: {pc_stall, if_id_stall, if_id_flush,
// id_exe_stall, id_exe_flush, exe_mem_flush, mc_timeout}.
module tb_pipe_ctrl;

    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] LU = 7'b1100100;
    localparam logic [6:0] BR = 7'b0010100;
    localparam logic [6:0] FL = 7'b0010000;
    localparam logic [6:0] MC = 7'b1101010;
    localparam logic [6:0] TO = 7'b0000001;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] EXP_STALLS = 32'd10;
    localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    typedef struct {
        logic [4:0] rs1;
        logic       re1;
        logic [4:0] rs2;
        logic       re2;
        logic       ld;
        logic [4:0] wa;
        logic       st;
        logic       dn;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    vec_t tbl[17];

    pipe_ctrl_if #(.RADDR_WIDTH(5)) bus ();

    pipe_ctrl #(
        .RADDR_WIDTH (5),
        .MC_TIMEOUT  (64),
        .CNT_WIDTH   (7)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic re1,
                                input logic [4:0] rs2, input logic re2,
                                input logic ld, input logic [4:0] wa,
                                input logic st, input logic dn,
                                input logic br, input logic [6:0] exp);
        vec_t v;
        v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2; v.ld = ld;
        v.wa = wa; v.st = st; v.dn = dn; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_rs1_raddr_i     = v.rs1;
        bus.id_rs1_re_i        = v.re1;
        bus.id_rs2_raddr_i     = v.rs2;
        bus.id_rs2_re_i        = v.re2;
        bus.exe_mem_read_i     = v.ld;
        bus.exe_reg_waddr_i    = v.wa;
        bus.exe_mc_start_i     = v.st;
        bus.exe_mc_done_i      = v.dn;
        bus.exe_branch_taken_i = v.br;
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {bus.pc_stall_o, bus.if_id_stall_o, bus.if_id_flush_o,
               bus.id_exe_stall_o, bus.id_exe_flush_o, bus.exe_mem_flush_o,
               bus.mc_timeout_o};
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // One cycle: drive after the falling edge, check before the rising edge.
    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        apply(v);
        #1;
        chk(name, v.exp);
    endtask

    initial begin
        vec_t idle, lu, st, dn, br, lu_br;
        n_checks = 0;
        n_pass   = 0;

        idle  = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z);
        lu    = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU);
        st    = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, MC);
        dn    = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z);
        br    = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BR);
        lu_br = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, BR);

        tbl[0]  = idle;
        tbl[1]  = lu;
        tbl[2]  = idle;
        tbl[3]  = mk(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, Z);
        tbl[4]  = mk(5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU);
        tbl[5]  = mk(5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, Z);
        tbl[6]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, Z);
        tbl[7]  = lu_br;
        tbl[8]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, FL);
        tbl[9]  = idle;
        tbl[10] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, Z);
        tbl[11] = st;
        tbl[12] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, MC);
        tbl[13] = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, MC);
        tbl[14] = dn;
        tbl[15] = idle;
        tbl[16] = lu;

        // Reset with a live load-use pattern: every output forced low.
        rst_n = 1'b0;
        apply(lu);
        #3;
        chk("reset_outputs", Z);
        chk32("reset_stall_cnt", bus.stall_cycles_o, 32'd0);
        chk32("reset_flush_cnt", bus.flush_cycles_o, 32'd0);
        @(negedge clk);
        apply(idle);
        @(negedge clk);
        rst_n = 1'b1;

        // 10-cycle multi-cycle op, then one redirect; feeds the perf counters.
        step(st, "mc10_start");
        for (int i = 1; i < 10; i++) begin
            vec_t w;
            w = idle;
            w.exp = MC;
            step(w, $sformatf("mc10_wait%0d", i));
        end
        step(dn, "mc10_done");
        step(br, "br_taken");
        begin
            vec_t f;
            f = idle;
            f.exp = FL;
            step(f, "br_flush");
        end
        step(idle, "br_after");
        chk32("perf_stalls", bus.stall_cycles_o, EXP_STALLS);
        chk32("perf_flushes", bus.flush_cycles_o, EXP_FLUSHES);

        // Per-cycle vector table.
        for (int i = 0; i < 17; i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Timeout: done never arrives; pulse on the 64th MC_WAIT cycle.
        step(st, "to_start");
        for (int i = 1; i < 64; i++) begin
            vec_t w;
            w = idle;
            w.exp = MC;
            step(w, $sformatf("to_wait%0d", i));
        end
        begin
            vec_t t;
            t = idle;
            t.exp = TO;
            step(t, "to_pulse");
        end
        step(lu, "to_back_in_run");
        step(idle, "to_idle");

        // Asynchronous reset in the middle of MC_WAIT.
        step(st, "ar_start");
        begin
            vec_t w;
            w = idle;
            w.exp = MC;
            step(w, "ar_wait1");
            step(w, "ar_wait2");
            @(negedge clk);
            apply(w);
            #1;
            chk("ar_wait3", MC);
            #2;
            rst_n = 1'b0;
            #1;
            chk("ar_async_clear", Z);
            chk32("ar_stall_cnt", bus.stall_cycles_o, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle);
        #1;
        chk("ar_release_idle", Z);
        step(lu, "ar_run_loaduse");
        step(idle, "ar_final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
